mem_xfer: RTL

// - Memory-side initiator for the CHIP-8 core. Drives the read/write port of the
//   4 KiB byte memory and performs multi-byte transfers for Fx55 (store V0..Vx),
//   Fx65 (load V0..Vx) and Fx33 (BCD store). Sits between the CPU control FSM,
//   the V register file and the memory; only this block drives memory during a transfer.

---
 rtl/chip8_pkg.sv | 33 +++
 rtl/mem_xfer_bcd8.sv | 27 ++
 rtl/mem_xfer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 memory transfer engine.
// Holds the default widths, command op codes, FSM state encoding and address helper.
package chip8_pkg;

    localparam int XFER_ADDR_W = 12;
    localparam int XFER_DATA_W = 8;
    localparam int XFER_REG_W  = 4;

    typedef enum logic [1:0] {
        OP_STORE = 2'd0,
        OP_LOAD  = 2'd1,
        OP_BCD   = 2'd2,
        OP_RSVD  = 2'd3
    } xfer_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STORE     = 3'd1,
        ST_LOAD_REQ  = 3'd2,
        ST_LOAD_WAIT = 3'd3,
        ST_BCD       = 3'd4,
        ST_DONE      = 3'd5
    } xfer_state_e;

    // Byte offset from the I register; the sum wraps at the top of memory.
    function automatic logic [XFER_ADDR_W-1:0] addr_offset(
        input logic [XFER_ADDR_W-1:0] base,
        input logic [XFER_REG_W-1:0]  off
    );
        return base + XFER_ADDR_W'(off);
    endfunction

endpackage

// File: rtl/mem_xfer_bcd8.sv
// Combinational 8-bit binary to three decimal digits (hundreds/tens/ones).
// Uses shift-and-add-3 so no divider is inferred.
module bcd8 (
    input  logic [7:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [19:0] shift_s;

    // Correct each BCD digit that would overflow before every left shift.
    always_comb begin
        shift_s = {12'd0, bin};
        for (int k = 0; k < 8; k++) begin
            shift_s[11:8]  = (shift_s[11:8]  >= 4'd5) ? shift_s[11:8]  + 4'd3 : shift_s[11:8];
            shift_s[15:12] = (shift_s[15:12] >= 4'd5) ? shift_s[15:12] + 4'd3 : shift_s[15:12];
            shift_s[19:16] = (shift_s[19:16] >= 4'd5) ? shift_s[19:16] + 4'd3 : shift_s[19:16];
            shift_s        = {shift_s[18:0], 1'b0};
        end
    end

    assign hundreds = shift_s[19:16];
    assign tens     = shift_s[15:12];
    assign ones     = shift_s[11:8];

endmodule

// File: rtl/mem_xfer.sv
// Memory-side initiator for the CHIP-8 core: Fx55 store, Fx65 load and Fx33 BCD.
// All strobes, indices and data toward memory and the register file are registered.
module mem_xfer
    import chip8_pkg::*;
#(
    parameter int ADDR_W = XFER_ADDR_W,
    parameter int DATA_W = XFER_DATA_W,
    parameter int REG_W  = XFER_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] base,
    input  logic [REG_W-1:0]  last,
    input  logic [DATA_W-1:0] bcd_val,
    output logic              busy,
    output logic              done,
    output logic [REG_W-1:0]  reg_idx,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_we,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_idx,
    input  logic [DATA_W-1:0] mem_read_byte,
    input  logic              mem_read_ack,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_idx,
    output logic [DATA_W-1:0] mem_write_byte
);

    xfer_state_e       state_r, state_s;
    logic [REG_W-1:0]  i_r, i_s;
    logic [ADDR_W-1:0] base_r, base_s;
    logic [REG_W-1:0]  last_r, last_s;
    logic [DATA_W-1:0] bcd_r, bcd_s;

    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [REG_W-1:0]  reg_idx_r, reg_idx_s;
    logic              reg_we_r, reg_we_s;
    logic [DATA_W-1:0] reg_wdata_r, reg_wdata_s;
    logic              mem_read_r, mem_read_s;
    logic [ADDR_W-1:0] mem_read_idx_r, mem_read_idx_s;
    logic              mem_write_r, mem_write_s;
    logic [ADDR_W-1:0] mem_write_idx_r, mem_write_idx_s;
    logic [DATA_W-1:0] mem_write_byte_r, mem_write_byte_s;

    logic [3:0]        hund_s, tens_s, ones_s;
    logic [REG_W-1:0]  i_inc_s;

    bcd8 u_bcd8 (
        .bin      (bcd_r),
        .hundreds (hund_s),
        .tens     (tens_s),
        .ones     (ones_s)
    );

    assign i_inc_s = i_r + REG_W'(1);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_s          = state_r;
        i_s              = i_r;
        base_s           = base_r;
        last_s           = last_r;
        bcd_s            = bcd_r;
        busy_s           = busy_r;
        done_s           = 1'b0;
        reg_idx_s        = reg_idx_r;
        reg_we_s         = 1'b0;
        reg_wdata_s      = reg_wdata_r;
        mem_read_s       = 1'b0;
        mem_read_idx_s   = mem_read_idx_r;
        mem_write_s      = 1'b0;
        mem_write_idx_s  = mem_write_idx_r;
        mem_write_byte_s = mem_write_byte_r;

        case (state_r)
            ST_IDLE: begin
                // The cycle showing the done pulse is still part of the old command.
                if (start && !done_r) begin
                    base_s    = base;
                    last_s    = last;
                    bcd_s     = bcd_val;
                    i_s       = {REG_W{1'b0}};
                    reg_idx_s = {REG_W{1'b0}};
                    busy_s    = 1'b1;
                    case (xfer_op_e'(op))
                        OP_STORE: state_s = ST_STORE;
                        OP_LOAD: begin
                            state_s        = ST_LOAD_REQ;
                            mem_read_s     = 1'b1;
                            mem_read_idx_s = base;
                        end
                        OP_BCD:   state_s = ST_BCD;
                        default:  state_s = ST_DONE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_STORE: begin
                mem_write_s      = 1'b1;
                mem_write_idx_s  = addr_offset(base_r, i_r);
                mem_write_byte_s = reg_rdata;
                if (i_r == last_r) begin
                    state_s = ST_DONE;
                end else begin
                    i_s       = i_inc_s;
                    reg_idx_s = i_inc_s;
                end
            end

            ST_LOAD_REQ: begin
                state_s = ST_LOAD_WAIT;
            end

            ST_LOAD_WAIT: begin
                if (mem_read_ack) begin
                    reg_we_s    = 1'b1;
                    reg_idx_s   = i_r;
                    reg_wdata_s = mem_read_byte;
                    if (i_r == last_r) begin
                        state_s = ST_DONE;
                    end else begin
                        i_s            = i_inc_s;
                        state_s        = ST_LOAD_REQ;
                        mem_read_s     = 1'b1;
                        mem_read_idx_s = addr_offset(base_r, i_inc_s);
                    end
                end else begin
                    state_s = ST_LOAD_WAIT;
                end
            end

            ST_BCD: begin
                mem_write_s     = 1'b1;
                mem_write_idx_s = addr_offset(base_r, i_r);
                case (i_r)
                    REG_W'(0): mem_write_byte_s = DATA_W'(hund_s);
                    REG_W'(1): mem_write_byte_s = DATA_W'(tens_s);
                    default:   mem_write_byte_s = DATA_W'(ones_s);
                endcase
                if (i_r == REG_W'(2)) begin
                    state_s = ST_DONE;
                end else begin
                    i_s = i_inc_s;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
            end

            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset clears every strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_r              <= {REG_W{1'b0}};
            base_r           <= {ADDR_W{1'b0}};
            last_r           <= {REG_W{1'b0}};
            bcd_r            <= {DATA_W{1'b0}};
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            reg_idx_r        <= {REG_W{1'b0}};
            reg_we_r         <= 1'b0;
            reg_wdata_r      <= {DATA_W{1'b0}};
            mem_read_r       <= 1'b0;
            mem_read_idx_r   <= {ADDR_W{1'b0}};
            mem_write_r      <= 1'b0;
            mem_write_idx_r  <= {ADDR_W{1'b0}};
            mem_write_byte_r <= {DATA_W{1'b0}};
        end else begin
            i_r              <= i_s;
            base_r           <= base_s;
            last_r           <= last_s;
            bcd_r            <= bcd_s;
            busy_r           <= busy_s;
            done_r           <= done_s;
            reg_idx_r        <= reg_idx_s;
            reg_we_r         <= reg_we_s;
            reg_wdata_r      <= reg_wdata_s;
            mem_read_r       <= mem_read_s;
            mem_read_idx_r   <= mem_read_idx_s;
            mem_write_r      <= mem_write_s;
            mem_write_idx_r  <= mem_write_idx_s;
            mem_write_byte_r <= mem_write_byte_s;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign reg_idx        = reg_idx_r;
    assign reg_we         = reg_we_r;
    assign reg_wdata      = reg_wdata_r;
    assign mem_read       = mem_read_r;
    assign mem_read_idx   = mem_read_idx_r;
    assign mem_write      = mem_write_r;
    assign mem_write_idx  = mem_write_idx_r;
    assign mem_write_byte = mem_write_byte_r;

endmodule
